// File: rtl/execute_stage_mc.sv
// Execute stage with its own EX/MEM pipeline register: operand forwarding,
// a single-cycle ALU and an iterative shift-add multiplier.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | single-cycle ops pass through; a MUL is captured here
// ST_MUL  | one shift-add step per edge; result written at last count
module execute_stage_mc #(
  parameter int N_BITS     = 32,
  parameter int N_REG_ADDR = 5,
  parameter bit MUL_EN     = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_flush,
  input  logic                  i_stall,
  input  logic [3:0]            i_alu_op,
  input  logic                  i_alu_src,
  input  logic                  i_reg_dst,
  input  logic [N_REG_ADDR-1:0] i_rs,
  input  logic [N_REG_ADDR-1:0] i_rt,
  input  logic [N_REG_ADDR-1:0] i_rd,
  input  logic [N_BITS-1:0]     i_data_a,
  input  logic [N_BITS-1:0]     i_data_b,
  input  logic [N_BITS-1:0]     i_imm,
  input  logic [4:0]            i_shamt,
  input  logic                  i_mem_to_reg,
  input  logic                  i_reg_write,
  input  logic                  i_mem_write,
  input  logic                  i_mem_read,
  input  logic [N_REG_ADDR-1:0] i_wb_rd,
  input  logic                  i_wb_reg_write,
  input  logic [N_BITS-1:0]     i_wb_data,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [N_BITS-1:0]     o_alu_result,
  output logic                  o_zero,
  output logic [N_BITS-1:0]     o_store_data,
  output logic [N_REG_ADDR-1:0] o_write_reg,
  output logic                  o_mem_to_reg,
  output logic                  o_reg_write,
  output logic                  o_mem_write,
  output logic                  o_mem_read
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  localparam int            CW   = $clog2(N_BITS);
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [N_BITS-1:0]     mul_a_q, mul_a_d;
  logic [N_BITS-1:0]     mul_b_q, mul_b_d;
  logic [N_BITS-1:0]     acc_q, acc_d;

  logic                  valid_q, valid_d;
  logic [N_BITS-1:0]     alu_result_q, alu_result_d;
  logic                  zero_q, zero_d;
  logic [N_BITS-1:0]     store_data_q, store_data_d;
  logic [N_REG_ADDR-1:0] write_reg_q, write_reg_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_read_q, mem_read_d;

  logic [N_BITS-1:0]     fwd_a, fwd_b, op_b, alu_res, mul_step, ld_res;
  logic                  is_mul, mul_last, ld, bub;

  assign is_mul   = MUL_EN && (i_alu_op == OP_MUL);
  assign mul_last = (state_q == ST_MUL) && (count_q == LAST);
  assign mul_step = acc_q + (mul_b_q[0] ? mul_a_q : '0);

  // Operand forwarding; the EX/MEM result is preferred over MEM/WB, loads excluded
  always_comb begin
    fwd_a = i_data_a;
    if (valid_q && reg_write_q && !mem_read_q && write_reg_q == i_rs && i_rs != '0)
      fwd_a = alu_result_q;
    else if (i_wb_reg_write && i_wb_rd == i_rs && i_rs != '0)
      fwd_a = i_wb_data;
    fwd_b = i_data_b;
    if (valid_q && reg_write_q && !mem_read_q && write_reg_q == i_rt && i_rt != '0)
      fwd_b = alu_result_q;
    else if (i_wb_reg_write && i_wb_rd == i_rt && i_rt != '0)
      fwd_b = i_wb_data;
    op_b = i_alu_src ? i_imm : fwd_b;
  end

  // Single-cycle ALU; MUL falls back to ADD when the multiplier is absent
  always_comb begin
    alu_res = '0;
    case (i_alu_op)
      OP_ADD, OP_MUL: alu_res = fwd_a + op_b;
      OP_SUB:  alu_res = fwd_a - op_b;
      OP_AND:  alu_res = fwd_a & op_b;
      OP_OR:   alu_res = fwd_a | op_b;
      OP_XOR:  alu_res = fwd_a ^ op_b;
      OP_NOR:  alu_res = ~(fwd_a | op_b);
      OP_SLT:  alu_res = {{(N_BITS-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(N_BITS-1){1'b0}}, (fwd_a < op_b)};
      OP_SLL:  alu_res = op_b << i_shamt;
      OP_SRL:  alu_res = op_b >> i_shamt;
      OP_SRA:  alu_res = N_BITS'($signed(op_b) >>> i_shamt);
      OP_LUI:  alu_res = {{(N_BITS-16){1'b0}}, i_imm[15:0]} << 16;
      default: alu_res = '0;
    endcase
  end

  // Handshake back to ID/EX: hold while stalled or until the MUL's last step
  always_comb begin
    o_busy = i_stall
           | ((state_q == ST_IDLE) && i_valid && is_mul)
           | ((state_q == ST_MUL) && (count_q != LAST));
  end

  // Next-state logic for the FSM, multiplier datapath and EX/MEM register
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    acc_d        = acc_q;
    valid_d      = valid_q;
    alu_result_d = alu_result_q;
    zero_d       = zero_q;
    store_data_d = store_data_q;
    write_reg_d  = write_reg_q;
    mem_to_reg_d = mem_to_reg_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    mem_read_d   = mem_read_q;
    ld           = 1'b0;
    bub          = 1'b0;
    ld_res       = alu_res;

    if (i_flush) begin
      state_d = ST_IDLE;
      count_d = '0;
      bub     = 1'b1;
    end else if (!i_stall) begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid && is_mul) begin
            state_d = ST_MUL;
            count_d = '0;
            acc_d   = '0;
            mul_a_d = fwd_a;
            mul_b_d = op_b;
            bub     = 1'b1;
          end else if (i_valid) begin
            ld = 1'b1;
          end else begin
            bub = 1'b1;
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            state_d = ST_IDLE;
            count_d = '0;
            ld      = 1'b1;
            ld_res  = mul_step;
          end else begin
            acc_d   = mul_step;
            mul_a_d = mul_a_q << 1;
            mul_b_d = mul_b_q >> 1;
            count_d = count_q + 1'b1;
            bub     = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
          bub     = 1'b1;
        end
      endcase
    end

    if (bub) begin
      valid_d      = 1'b0;
      alu_result_d = '0;
      zero_d       = 1'b0;
      store_data_d = '0;
      write_reg_d  = '0;
      mem_to_reg_d = 1'b0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      mem_read_d   = 1'b0;
    end else if (ld) begin
      valid_d      = 1'b1;
      alu_result_d = ld_res;
      zero_d       = (ld_res == '0);
      store_data_d = fwd_b;
      write_reg_d  = i_reg_dst ? i_rd : i_rt;
      mem_to_reg_d = i_mem_to_reg;
      reg_write_d  = i_reg_write;
      mem_write_d  = i_mem_write;
      mem_read_d   = i_mem_read;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      acc_q        <= '0;
      valid_q      <= 1'b0;
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      store_data_q <= '0;
      write_reg_q  <= '0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      acc_q        <= acc_d;
      valid_q      <= valid_d;
      alu_result_q <= alu_result_d;
      zero_q       <= zero_d;
      store_data_q <= store_data_d;
      write_reg_q  <= write_reg_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_alu_result = alu_result_q;
  assign o_zero       = zero_q;
  assign o_store_data = store_data_q;
  assign o_write_reg  = write_reg_q;
  assign o_mem_to_reg = mem_to_reg_q;
  assign o_reg_write  = reg_write_q;
  assign o_mem_write  = mem_write_q;
  assign o_mem_read   = mem_read_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc: ALU, forwarding, multiplier, stall/flush.
module tb_execute_stage_mc;

  logic        i_clk = 1'b0;
  logic        i_reset, i_valid, i_flush, i_stall;
  logic [3:0]  i_alu_op;
  logic        i_alu_src, i_reg_dst;
  logic [4:0]  i_rs, i_rt, i_rd;
  logic [31:0] i_data_a, i_data_b, i_imm;
  logic [4:0]  i_shamt;
  logic        i_mem_to_reg, i_reg_write, i_mem_write, i_mem_read;
  logic [4:0]  i_wb_rd;
  logic        i_wb_reg_write;
  logic [31:0] i_wb_data;
  logic        o_busy, o_valid, o_zero;
  logic [31:0] o_alu_result, o_store_data;
  logic [4:0]  o_write_reg;
  logic        o_mem_to_reg, o_reg_write, o_mem_write, o_mem_read;

  int checks = 0;
  int errors = 0;

  execute_stage_mc #(.N_BITS(32), .N_REG_ADDR(5), .MUL_EN(1'b1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_flush(i_flush),
    .i_stall(i_stall), .i_alu_op(i_alu_op), .i_alu_src(i_alu_src),
    .i_reg_dst(i_reg_dst), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_imm(i_imm), .i_shamt(i_shamt),
    .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write),
    .i_mem_write(i_mem_write), .i_mem_read(i_mem_read), .i_wb_rd(i_wb_rd),
    .i_wb_reg_write(i_wb_reg_write), .i_wb_data(i_wb_data), .o_busy(o_busy),
    .o_valid(o_valid), .o_alu_result(o_alu_result), .o_zero(o_zero),
    .o_store_data(o_store_data), .o_write_reg(o_write_reg),
    .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write),
    .o_mem_write(o_mem_write), .o_mem_read(o_mem_read)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 0; i_flush = 0; i_stall = 0; i_alu_op = 0; i_alu_src = 0;
    i_reg_dst = 0; i_rs = 0; i_rt = 0; i_rd = 0; i_data_a = 0; i_data_b = 0;
    i_imm = 0; i_shamt = 0; i_mem_to_reg = 0; i_reg_write = 0; i_mem_write = 0;
    i_mem_read = 0; i_wb_rd = 0; i_wb_reg_write = 0; i_wb_data = 0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    idle_inputs();
    i_valid = 1; i_alu_op = op; i_rs = rs; i_rt = rt; i_rd = rd;
    i_reg_dst = 1; i_reg_write = 1; i_data_a = a; i_data_b = b;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_reset = 1;
    step(); step();
    checks++;
    if (o_valid !== 1'b0 || o_alu_result !== 32'h0 || o_busy !== 1'b0 || o_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL reset got valid=%b res=%h busy=%b rw=%b exp all 0", o_valid, o_alu_result, o_busy, o_reg_write);
    end
    i_reset = 0;
  endtask

  task automatic test_add();
    issue(4'd0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    step();
    checks++;
    if (o_alu_result !== 32'd12 || o_zero !== 1'b0 || o_valid !== 1'b1 || o_write_reg !== 5'd3 || o_store_data !== 32'd7) begin
      errors++;
      $display("FAIL add got res=%0d z=%b v=%b wr=%0d sd=%0d exp 12 0 1 3 7", o_alu_result, o_zero, o_valid, o_write_reg, o_store_data);
    end
  endtask

  task automatic test_forwarding();
    // EX/MEM holds $3=12
    issue(4'd1, 5'd3, 5'd1, 5'd4, 32'd0, 32'd2);
    step();
    checks++;
    if (o_alu_result !== 32'd10 || o_write_reg !== 5'd4) begin
      errors++;
      $display("FAIL fwd_exmem got %0d wr %0d exp 10 wr 4", o_alu_result, o_write_reg);
    end
    issue(4'd0, 5'd4, 5'd5, 5'd6, 32'd0, 32'd1);
    i_wb_reg_write = 1; i_wb_rd = 5'd4; i_wb_data = 32'd100;
    step();
    checks++;
    if (o_alu_result !== 32'd11) begin
      errors++;
      $display("FAIL fwd_priority got %0d exp 11", o_alu_result);
    end
    issue(4'd0, 5'd7, 5'd8, 5'd9, 32'd1, 32'd0);
    i_wb_reg_write = 1; i_wb_rd = 5'd8; i_wb_data = 32'd40;
    step();
    checks++;
    if (o_alu_result !== 32'd41 || o_store_data !== 32'd40) begin
      errors++;
      $display("FAIL fwd_memwb got %0d sd %0d exp 41 sd 40", o_alu_result, o_store_data);
    end
    issue(4'd0, 5'd0, 5'd0, 5'd0, 32'd50, 32'd0);
    step();
    issue(4'd0, 5'd0, 5'd10, 5'd11, 32'd1, 32'd2);
    i_wb_reg_write = 1; i_wb_rd = 5'd0; i_wb_data = 32'd77;
    step();
    checks++;
    if (o_alu_result !== 32'd3) begin
      errors++;
      $display("FAIL fwd_r0 got %0d exp 3", o_alu_result);
    end
    issue(4'd0, 5'd0, 5'd0, 5'd12, 32'd20, 32'd0);
    i_mem_read = 1;
    step();
    issue(4'd0, 5'd12, 5'd0, 5'd13, 32'd3, 32'd4);
    step();
    checks++;
    if (o_alu_result !== 32'd7) begin
      errors++;
      $display("FAIL fwd_load_excluded got %0d exp 7", o_alu_result);
    end
  endtask

  task automatic test_alu();
    logic [3:0]  t_op[10]  = '{4'd6, 4'd7, 4'd10, 4'd9, 4'd8, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
    logic [31:0] t_a[10]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h3,
                               32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'd5};
    logic [31:0] t_b[10]   = '{32'h1, 32'h1, 32'h8000_0000, 32'h8000_0000, 32'h3,
                               32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00, 32'd5};
    logic [4:0]  t_sh[10]  = '{5'd0, 5'd0, 5'd4, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [31:0] t_exp[10] = '{32'h1, 32'h0, 32'hF800_0000, 32'h0800_0000, 32'h30,
                               32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h000F_000F, 32'h0};
    for (int k = 0; k < 10; k++) begin
      issue(t_op[k], 5'd0, 5'd0, 5'd1, t_a[k], t_b[k]);
      i_shamt = t_sh[k];
      step();
      checks++;
      if (o_alu_result !== t_exp[k] || o_zero !== (t_exp[k] == 32'h0)) begin
        errors++;
        $display("FAIL alu_op%0d got %h z=%b exp %h", t_op[k], o_alu_result, o_zero, t_exp[k]);
      end
    end
    issue(4'd11, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0);
    i_alu_src = 1; i_imm = 32'hFFFF_1234;
    step();
    checks++;
    if (o_alu_result !== 32'h1234_0000) begin
      errors++;
      $display("FAIL lui got %h exp 12340000", o_alu_result);
    end
  endtask

  task automatic test_mul();
    int  busy_cycles = 0;
    bit  done = 0;
    bit  bubble_bad = 0;
    idle_inputs();
    step();
    issue(4'd12, 5'd1, 5'd2, 5'd9, 32'h0001_0003, 32'h0000_0005);
    #1;
    for (int k = 0; k < 40; k++) begin
      if (!done) begin
        if (o_busy) busy_cycles++;
        else done = 1;
        if (o_busy && o_valid !== 1'b0) bubble_bad = 1;
        if (k == 5) begin
          i_data_a = 32'hFFFF_FFFF;
          i_wb_reg_write = 1; i_wb_rd = 5'd1; i_wb_data = 32'h1234_5678;
        end
        step();
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL mul_timeout busy still %b after 40 cycles exp low", o_busy);
    end
    checks++;
    if (busy_cycles != 32) begin
      errors++;
      $display("FAIL mul_busy_cycles got %0d exp 32", busy_cycles);
    end
    checks++;
    if (bubble_bad) begin
      errors++;
      $display("FAIL mul_bubbles got valid=1 during multiply exp 0");
    end
    checks++;
    if (o_alu_result !== 32'h0005_000F || o_valid !== 1'b1 || o_write_reg !== 5'd9 || o_reg_write !== 1'b1) begin
      errors++;
      $display("FAIL mul_result got %h v=%b wr=%0d exp 0005000f 1 9", o_alu_result, o_valid, o_write_reg);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_mul_flush();
    issue(4'd12, 5'd0, 5'd0, 5'd2, 32'd3, 32'd4);
    step();
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre got busy=%b v=%b exp 1 0", o_busy, o_valid);
    end
    i_flush = 1;
    step();
    i_flush = 0;
    checks++;
    if (o_valid !== 1'b0 || o_alu_result !== 32'h0) begin
      errors++;
      $display("FAIL flush_bubble got v=%b res=%h exp 0 0", o_valid, o_alu_result);
    end
    i_valid = 0;
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle got busy=%b exp 0", o_busy);
    end
    issue(4'd0, 5'd0, 5'd0, 5'd3, 32'd1, 32'd1);
    step();
    checks++;
    if (o_alu_result !== 32'd2 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_next got %0d v=%b exp 2 1", o_alu_result, o_valid);
    end
  endtask

  task automatic test_stall();
    issue(4'd0, 5'd0, 5'd0, 5'd5, 32'd2, 32'd3);
    step();
    issue(4'd0, 5'd0, 5'd0, 5'd6, 32'd10, 32'd20);
    i_stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (o_alu_result !== 32'd5 || o_valid !== 1'b1 || o_write_reg !== 5'd5 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d got res=%0d v=%b wr=%0d busy=%b exp 5 1 5 1", k, o_alu_result, o_valid, o_write_reg, o_busy);
      end
    end
    i_stall = 0;
    step();
    checks++;
    if (o_alu_result !== 32'd30 || o_write_reg !== 5'd6) begin
      errors++;
      $display("FAIL stall_release got %0d wr %0d exp 30 wr 6", o_alu_result, o_write_reg);
    end
    i_stall = 1; i_flush = 1;
    step();
    i_stall = 0; i_flush = 0;
    checks++;
    if (o_valid !== 1'b0 || o_reg_write !== 1'b0 || o_alu_result !== 32'h0) begin
      errors++;
      $display("FAIL stall_flush got v=%b rw=%b res=%h exp 0 0 0", o_valid, o_reg_write, o_alu_result);
    end
  endtask

  task automatic test_mul_reset();
    issue(4'd12, 5'd0, 5'd0, 5'd7, 32'd9, 32'd9);
    step();
    for (int k = 0; k < 5; k++) step();
    idle_inputs();
    i_reset = 1;
    step();
    i_reset = 0;
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_alu_result !== 32'h0 || o_write_reg !== 5'd0) begin
      errors++;
      $display("FAIL mul_reset got busy=%b v=%b res=%h wr=%0d exp all 0", o_busy, o_valid, o_alu_result, o_write_reg);
    end
    issue(4'd0, 5'd0, 5'd0, 5'd8, 32'd4, 32'd4);
    step();
    checks++;
    if (o_alu_result !== 32'd8 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_add got %0d v=%b exp 8 1", o_alu_result, o_valid);
    end
  endtask

  initial begin
    i_reset = 1;
    idle_inputs();
    test_reset();
    test_add();
    test_forwarding();
    test_alu();
    test_mul();
    test_mul_flush();
    test_stall();
    test_mul_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
